// File: rtl/alpha_muldiv.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) producing a HI:LO pair, one bit per cycle.
// Optional early termination is enabled by defining MULDIV_EARLY_OUT_EN.
module alpha_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     div_trial, div_diff;
  logic               cnt_last, mul_last, div_last;

  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    prod_fix  = neg_q  ? -acc_q : acc_q;
    quo_fix   = neg_q  ? -quo_q : quo_q;
    rem_fix   = rneg_q ? -rem_q : rem_q;

    // Restoring step: partial remainder is always < divisor, so trial fits WIDTH+1 bits.
    div_trial = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, dvsr_q};

    cnt_last  = (cnt_q == CW'(WIDTH));
`ifdef MULDIV_EARLY_OUT_EN
    mul_last  = cnt_last || (mplier_q == '0);
    div_last  = cnt_last || bz_q;
`else
    mul_last  = cnt_last;
    div_last  = cnt_last;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    bz_d       = bz_q;
    a_raw_d    = a_raw_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = op[1] ? S_DIV : S_MUL;
          cnt_d    = '0;
          neg_d    = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rneg_d   = is_signed & src_a[WIDTH-1];
          bz_d     = (src_b == '0);
          a_raw_d  = src_a;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          rem_d    = '0;
          quo_d    = a_mag;
          dvsr_d   = b_mag;
        end
      end

      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (mul_last) begin
          state_d    = S_FIN;
          done_d     = 1'b1;
          hi_d       = prod_fix[2*WIDTH-1:WIDTH];
          lo_d       = prod_fix[WIDTH-1:0];
          div_zero_d = 1'b0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end

      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (div_last) begin
          state_d    = S_FIN;
          done_d     = 1'b1;
          div_zero_d = bz_q;
          if (bz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      bz_q       <= 1'b0;
      a_raw_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      bz_q       <= bz_d;
      a_raw_q    <= a_raw_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alpha_muldiv.sv
// Directed, table-driven bench for alpha_muldiv at WIDTH=32, plus cancel/busy-start/reset sequences.
module tb_alpha_muldiv;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         cancel;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] last_hi, last_lo;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[15];

  alpha_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one start cycle, then scrambles the operand inputs to prove they were latched.
  task automatic launch(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic with_cancel);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = with_cancel;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    op = ~o; src_a = ~a; src_b = b ^ 32'h5A5A_A5A5;
    chk({nm, " busy_after_start"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    chk({nm, " done_seen"}, {63'd0, done}, 64'd1);
  endtask

  task automatic do_op(input vec_t v);
    int n;
    launch(v.name, v.op, v.a, v.b, 1'b0);
    wait_done(v.name, n);
    chk({v.name, " hi"}, {32'd0, hi}, {32'd0, v.hi});
    chk({v.name, " lo"}, {32'd0, lo}, {32'd0, v.lo});
    chk({v.name, " div_zero"}, {63'd0, div_zero}, {63'd0, v.dz});
`ifdef MULDIV_EARLY_OUT_EN
    if (v.b == '0) chk({v.name, " latency"}, 64'(n), 64'd1);
    else           chk({v.name, " latency_bound"}, {63'd0, (n <= 33)}, 64'd1);
`else
    chk({v.name, " latency"}, 64'(n), 64'd33);
`endif
    @(posedge clk); #1;
    chk({v.name, " done_pulse"}, {62'd0, done, busy}, 64'd0);
    last_hi = v.hi;
    last_lo = v.lo;
  endtask

  initial begin
    int n;
    logic saw_done;

    vecs[0]  = '{"mult_m1x2",     OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{"multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{"divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3]  = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{"div_min_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{"divu_5_0",      OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{"multu_b0",      OP_MULTU, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         1'b0};
    vecs[7]  = '{"mult_min_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{"mult_3_m5",     OP_MULT,  32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[9]  = '{"div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{"div_min_0",     OP_DIV,   32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{"multu_2p16sq",  OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0};
    vecs[12] = '{"divu_max_1",    OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{"divu_3_10",     OP_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         1'b0};
    vecs[14] = '{"multu_ffff_sq", OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0,         32'hFFFE_0001, 1'b0};

    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; cancel = 1'b0;
    last_hi = '0; last_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) do_op(vecs[i]);

    // Cancel mid-multiply; cancel asserted alongside start in IDLE must not block acceptance.
    launch("cancel", OP_MULTU, 32'd3, 32'h8000_0001, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel busy_done", {62'd0, busy, done}, 64'd0);
    chk("cancel hilo_kept", {hi, lo}, {last_hi, last_lo});
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("cancel no_done", {63'd0, saw_done}, 64'd0);

    // A second start while busy is ignored; result and timing belong to the first op.
    launch("busy_start", OP_MULTU, 32'd6, 32'h8000_0007, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", n);
    chk("busy_start latency", 64'(n + 6), 64'd33);
    chk("busy_start hilo", {hi, lo}, 64'h0000_0003_0000_002A);
    @(posedge clk); #1;
    chk("busy_start idle", {62'd0, done, busy}, 64'd0);

    // Reset mid-divide clears everything; a fresh op afterwards completes normally.
    launch("rst_mid", OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid flags", {61'd0, busy, done, div_zero}, 64'd0);
    chk("rst_mid hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
